// File: rtl/step_seq_pkg.sv
// Shared definitions for the step sequencer: one-hot state encoding,
// pass-count floor and the accumulator wrap threshold.
package step_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    RUN  = 3'b010,
    DONE = 3'b100
  } state_t;

  localparam int unsigned MIN_PASSES = 1;
  localparam int unsigned BPM_W      = 10;
  localparam int unsigned PASS_W     = 7;

  // Phase units per step period: CLK_HZ*60, so that adding BPM*SPB each
  // clock produces one wrap per step.
  function automatic longint unsigned thresh(input longint unsigned clk_hz);
    return clk_hz * 64'd60;
  endfunction

endpackage

// File: rtl/tempo_tick_gen.sv
// Phase accumulator that emits a combinational tick each cycle the running
// sum reaches CLK_HZ*60; the remainder is carried so tempo stays exact.
module tempo_tick_gen
  import step_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned ACC_W  = 33
) (
  input  logic             CLOCK_50,
  input  logic             nReset,
  input  logic             clear,
  input  logic             run,
  input  logic [ACC_W-1:0] inc,
  output logic             tick
);

  localparam logic [ACC_W-1:0] THRESH = ACC_W'(thresh(64'(CLK_HZ)));

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum;

  always_comb begin
    sum   = acc_q + inc;
    acc_d = acc_q;
    tick  = 1'b0;
    if (clear) begin
      acc_d = '0;
    end else if (run) begin
      if (sum >= THRESH) begin
        acc_d = sum - THRESH;
        tick  = 1'b1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/step_player.sv
// Playback engine: walks a step index over STEPS positions for the latched
// number of passes, paced by tempo_tick_gen, and hands play_en back upstream.
module step_player
  import step_seq_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned STEPS  = 16,
  parameter int unsigned STEP_W = 4,
  parameter int unsigned SPB    = 4,
  parameter int unsigned ACC_W  = 33
) (
  input  logic              CLOCK_50,
  input  logic              nReset,
  input  logic              Start,
  input  logic [BPM_W-1:0]  BPM,
  input  logic [PASS_W-1:0] Loops,
  output logic              play_en,
  output logic [STEP_W-1:0] step,
  output logic              step_tick,
  output logic [PASS_W-1:0] pass,
  output logic              done,
  output logic [2:0]        dbg_state
);

  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  state_t             state_q, state_d;
  logic               start_q;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [PASS_W-1:0]  pass_q, pass_d;
  logic [PASS_W-1:0]  passes_q, passes_d;
  logic [ACC_W-1:0]   inc_q, inc_d;
  logic               step_tick_q, step_tick_d;
  logic               done_q, done_d;
  logic               start_rise;
  logic               start_ok;
  logic               acc_clear;
  logic               tick;

  assign start_rise = Start & ~start_q;
  assign start_ok   = start_rise & (BPM != '0);

  tempo_tick_gen #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_tempo (
    .CLOCK_50 (CLOCK_50),
    .nReset   (nReset),
    .clear    (acc_clear),
    .run      (state_q == RUN),
    .inc      (inc_q),
    .tick     (tick)
  );

  // Abort takes priority over a same-cycle tick, which is discarded.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    pass_d      = pass_q;
    passes_d    = passes_q;
    inc_d       = inc_q;
    step_tick_d = 1'b0;
    done_d      = 1'b0;
    acc_clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d     = RUN;
          inc_d       = ACC_W'(BPM) * ACC_W'(SPB);
          passes_d    = (Loops == '0) ? PASS_W'(MIN_PASSES) : Loops;
          step_d      = '0;
          pass_d      = PASS_W'(1);
          step_tick_d = 1'b1;
          acc_clear   = 1'b1;
        end
      end
      RUN: begin
        if (!Start) begin
          state_d = IDLE;
          step_d  = '0;
          pass_d  = '0;
        end else if (tick) begin
          if (step_q != LAST_STEP) begin
            step_d      = step_q + STEP_W'(1);
            step_tick_d = 1'b1;
          end else if (pass_q < passes_q) begin
            step_d      = '0;
            pass_d      = pass_q + PASS_W'(1);
            step_tick_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        step_d  = '0;
        pass_d  = '0;
      end
      default: begin
        state_d = IDLE;
        step_d  = '0;
        pass_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      start_q     <= 1'b0;
      step_q      <= '0;
      pass_q      <= '0;
      passes_q    <= '0;
      inc_q       <= '0;
      step_tick_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= Start;
      step_q      <= step_d;
      pass_q      <= pass_d;
      passes_q    <= passes_d;
      inc_q       <= inc_d;
      step_tick_q <= step_tick_d;
      done_q      <= done_d;
    end
  end

  // Mealy term lets upstream see play_en in the very cycle Start rises;
  // gated by nReset so it stays low while reset is held.
  assign play_en   = nReset & ((state_q == RUN) | ((state_q == IDLE) & start_ok));
  assign step      = step_q;
  assign step_tick = step_tick_q;
  assign pass      = pass_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
